unsigned_seq_divider: RTL and testbench

- Sequential unsigned restoring divider. Companion "inverse" of the team's 32-bit shift-add multiplier.
- Takes an unsigned dividend and divisor and produces quotient and remainder, one quotient bit per clock.
- Sits in the same datapath lab harness as the multiplier and uses the same CLK/RST scheme.
- Adds a start/busy/valid handshake and divide-by-zero flagging.

---
 rtl/unsigned_seq_divider.sv | 115 +++++++++++
 tb/tb_unsigned_seq_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/unsigned_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/valid
// handshake, divide-by-zero returns all-ones quotient and the dividend as remainder.
module unsigned_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_Valid,
  output logic             Div_By_Zero,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH:0]   partial_rem;
  logic [WIDTH-1:0] q_shift;
  logic [CW-1:0]    count;

  // Restoring step: the trial value and compare are WIDTH+1 bits wide so a divisor
  // with its MSB set still compares correctly against the shifted-in remainder.
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;

  assign trial    = {partial_rem[WIDTH-1:0], q_shift[WIDTH-1]};
  assign trial_ge = (trial >= {1'b0, divisor_r});
  assign rem_next = trial_ge ? (trial - {1'b0, divisor_r}) : trial;
  assign q_next   = {q_shift[WIDTH-2:0], trial_ge};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of the order of statements or processes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting every always_comb output before the case keeps unlisted paths
  // from inferring latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = (in_divisor == '0) ? DONE : CALC;
      CALC: if (count == LAST_ITER) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state != IDLE);
    Div_Valid = (state == DONE);
  end

  // NOTE: every datapath register is reset, including operand copies, so an abort
  // via RST leaves no stale operand or partial result behind.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dividend_r  <= '0;
      divisor_r   <= '0;
      partial_rem <= '0;
      q_shift     <= '0;
      count       <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      Div_By_Zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dividend_r <= in_dividend;
            divisor_r  <= in_divisor;
            if (in_divisor == '0) begin
              Quotient    <= '1;
              Remainder   <= in_dividend;
              Div_By_Zero <= 1'b1;
            end else begin
              partial_rem <= '0;
              q_shift     <= in_dividend;
              count       <= '0;
            end
          end
        end
        CALC: begin
          partial_rem <= rem_next;
          q_shift     <= q_next;
          count       <= count + CW'(1);
          if (count == LAST_ITER) begin
            Quotient    <= q_next;
            Remainder   <= rem_next[WIDTH-1:0];
            Div_By_Zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_divider.sv
// Directed and randomized checks of unsigned_seq_divider: latency, handshake,
// divide-by-zero, ignored start while busy, mid-operation reset.
module tb_unsigned_seq_divider;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Div_Valid;
  logic        Div_By_Zero;
  logic        Busy;

  int checks   = 0;
  int failures = 0;

  unsigned_seq_divider #(.WIDTH(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Div_Valid   (Div_Valid),
    .Div_By_Zero (Div_By_Zero),
    .Busy        (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one start pulse, then scrambles the operand inputs every cycle while
  // waiting. lat counts edges after the acceptance edge until Div_Valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                        output int lat, output bit busy_ok);
    @(negedge CLK);
    start = 1'b1; in_dividend = a; in_divisor = b;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    lat = 0;
    busy_ok = Busy;
    while (!Div_Valid && lat < 100) begin
      if (!Busy) busy_ok = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1; in_dividend = 32'd9; in_divisor = 32'd3;
      end else begin
        start = 1'b0; in_dividend = $urandom; in_divisor = $urandom;
      end
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    start = 1'b0;
    if (!Busy) busy_ok = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [31:0] q, input logic [31:0] r, input logic dbz);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_valid"},   64'(Div_Valid), 64'd1);
    check({tag, "_q"},       64'(Quotient), 64'(q));
    check({tag, "_r"},       64'(Remainder), 64'(r));
    check({tag, "_dbz"},     64'(Div_By_Zero), 64'(dbz));
    @(negedge CLK);
    check({tag, "_valid_end"}, 64'(Div_Valid), 64'd0);
    check({tag, "_busy_end"},  64'(Busy), 64'd0);
  endtask

  initial begin
    int          lat;
    bit          busy_ok;
    bit          saw_valid;
    logic [31:0] a;
    logic [31:0] b;

    RST = 1'b1; start = 1'b0; in_dividend = '0; in_divisor = '0;
    repeat (2) @(negedge CLK);
    check("rst_q",     64'(Quotient), 64'd0);
    check("rst_r",     64'(Remainder), 64'd0);
    check("rst_valid", 64'(Div_Valid), 64'd0);
    check("rst_dbz",   64'(Div_By_Zero), 64'd0);
    check("rst_busy",  64'(Busy), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 100 / 7
    run_op(32'd100, 32'd7, -1, lat, busy_ok);
    check("d100_busy_held", 64'(busy_ok), 64'd1);
    check_result("d100", lat, 32, 32'd14, 32'd2, 1'b0);

    // Wide compare: divisor with MSB set
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, lat, busy_ok);
    check_result("wide", lat, 32, 32'd1, 32'd1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, -1, lat, busy_ok);
    check_result("by_one", lat, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Divide by zero, then results must hold through IDLE
    run_op(32'd5, 32'd0, -1, lat, busy_ok);
    check_result("dbz", lat, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    repeat (3) @(negedge CLK);
    check("dbz_hold_q",   64'(Quotient), 64'hFFFF_FFFF);
    check("dbz_hold_r",   64'(Remainder), 64'd5);
    check("dbz_hold_flg", 64'(Div_By_Zero), 64'd1);
    run_op(32'd3, 32'd10, -1, lat, busy_ok);
    check_result("after_dbz", lat, 32, 32'd0, 32'd3, 1'b0);

    // Start while busy is ignored
    run_op(32'd1000, 32'd10, 10, lat, busy_ok);
    check("ignore_busy_held", 64'(busy_ok), 64'd1);
    check_result("ignore", lat, 32, 32'd100, 32'd0, 1'b0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (Div_Valid || Busy) saw_valid = 1'b1;
    end
    check("ignore_no_second_op", 64'(saw_valid), 64'd0);

    // Reset mid-operation
    @(negedge CLK);
    start = 1'b1; in_dividend = 32'hDEAD_BEEF; in_divisor = 32'h1234;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (15) @(negedge CLK);
    check("mid_busy_before", 64'(Busy), 64'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_q",     64'(Quotient), 64'd0);
    check("mid_rst_r",     64'(Remainder), 64'd0);
    check("mid_rst_valid", 64'(Div_Valid), 64'd0);
    check("mid_rst_dbz",   64'(Div_By_Zero), 64'd0);
    check("mid_rst_busy",  64'(Busy), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (Div_Valid || Busy) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", 64'(saw_valid), 64'd0);
    run_op(32'd50, 32'd8, -1, lat, busy_ok);
    check_result("after_rst", lat, 32, 32'd6, 32'd2, 1'b0);

    // Randomized regression with targeted divisor classes
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = 32'd1;
        1: begin a = $urandom_range(0, 100000); b = a + 32'd1 + $urandom_range(0, 1000); end
        2: begin if (a == 0) a = 32'd1; b = a; end
        default: begin b = $urandom >> $urandom_range(0, 31); if (b == 0) b = 32'd1; end
      endcase
      run_op(a, b, -1, lat, busy_ok);
      check("rnd_latency", 64'(lat), 64'd32);
      check("rnd_q", 64'(Quotient), 64'(a / b));
      check("rnd_r", 64'(Remainder), 64'(a % b));
      check("rnd_identity", 64'(Quotient) * 64'(b) + 64'(Remainder), 64'(a));
      check("rnd_r_lt_d", 64'(Remainder < b), 64'd1);
      @(negedge CLK);
      check("rnd_single_pulse", 64'(Div_Valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
